// File: rtl/pipe_result_collector_pkg.sv
// rtl/pipe_result_collector_pkg.sv - shared widths, latency and result type for the arithmetic pipeline
package pipe_result_collector_pkg;

    // Result width of the arithmetic pipeline
    localparam int PRC_N = 10;

    // Operand-sample to result-valid latency of the arithmetic pipeline
    localparam int PRC_LAT = 3;

    typedef logic [PRC_N-1:0] result_t;

endpackage

// File: rtl/sync_fifo_fwft.sv
// rtl/sync_fifo_fwft.sv - first-word fall-through synchronous FIFO with occupancy count
module sync_fifo_fwft
    import pipe_result_collector_pkg::*;
#(
    parameter int N     = PRC_N,
    parameter int DEPTH = 4,
    localparam int LW   = $clog2(DEPTH + 1),
    localparam int PW   = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          i_clear,
    input  logic          i_wr_en,
    input  logic [N-1:0]  i_wr_data,
    input  logic          i_rd_en,
    output logic [N-1:0]  o_rd_data,
    output logic [LW-1:0] o_level,
    output logic          o_full,
    output logic          o_empty
);

    logic [N-1:0]  r_mem [DEPTH];
    logic [PW-1:0] r_wr_ptr;
    logic [PW-1:0] r_rd_ptr;
    logic [LW-1:0] r_level;

    logic w_rd;
    logic w_wr;

    // Full/empty come from the occupancy count so pointers can wrap freely
    assign o_full  = (r_level == LW'(DEPTH));
    assign o_empty = (r_level == '0);
    assign o_level = r_level;

    // A full FIFO still accepts a write when the head leaves in the same cycle
    assign w_rd = i_rd_en & ~o_empty;
    assign w_wr = i_wr_en & (~o_full | w_rd);

    // Storage is left unreset; the head is masked to zero while empty
    assign o_rd_data = o_empty ? '0 : r_mem[r_rd_ptr];

    // Storage write at the tail
    always_ff @(posedge clk) begin
        if (w_wr && !i_clear) begin
            r_mem[r_wr_ptr] <= i_wr_data;
        end
    end

    // Pointer and occupancy bookkeeping; clear overrides any read or write
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_level  <= '0;
        end else if (i_clear) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_level  <= '0;
        end else begin
            if (w_wr) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_rd) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            case ({w_wr, w_rd})
                2'b10:   r_level <= r_level + 1'b1;
                2'b01:   r_level <= r_level - 1'b1;
                default: r_level <= r_level;
            endcase
        end
    end

endmodule

// File: rtl/pipe_result_collector.sv
// rtl/pipe_result_collector.sv - realigns pipeline results with issue slots and queues them for a consumer
module pipe_result_collector
    import pipe_result_collector_pkg::*;
#(
    parameter int N      = PRC_N,
    parameter int LAT    = PRC_LAT,
    parameter int DEPTH  = 4,
    parameter int DROP_W = 8,
    localparam int LW    = $clog2(DEPTH + 1)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              clear,
    input  logic              issue_valid,
    input  logic [N-1:0]      data_in,
    output logic              out_valid,
    output logic [N-1:0]      out_data,
    input  logic              out_ready,
    output logic [LW-1:0]     level,
    output logic              overflow,
    output logic [DROP_W-1:0] drop_count
);

    logic [LAT-1:0]    r_dly;
    logic              r_overflow;
    logic [DROP_W-1:0] r_drop_count;

    logic w_cap;
    logic w_rd;
    logic w_full;
    logic w_empty;
    logic w_drop;

    // The last delay stage marks the cycle in which data_in carries a real result
    assign w_cap  = r_dly[LAT-1];
    assign w_rd   = out_valid & out_ready;
    assign w_drop = w_cap & w_full & ~w_rd;

    assign out_valid  = ~w_empty;
    assign overflow   = r_overflow;
    assign drop_count = r_drop_count;

    // Issue-valid delay line matched to the pipeline latency
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_dly <= '0;
        end else if (clear) begin
            r_dly <= '0;
        end else begin
            r_dly[0] <= issue_valid;
            for (int i = 1; i < LAT; i++) begin
                r_dly[i] <= r_dly[i-1];
            end
        end
    end

    // Sticky overflow flag and saturating count of results that found no room
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_overflow   <= 1'b0;
            r_drop_count <= '0;
        end else if (clear) begin
            r_overflow   <= 1'b0;
            r_drop_count <= '0;
        end else if (w_drop) begin
            r_overflow <= 1'b1;
            if (r_drop_count != '1) begin
                r_drop_count <= r_drop_count + 1'b1;
            end
        end
    end

    sync_fifo_fwft #(
        .N     (N),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .i_clear   (clear),
        .i_wr_en   (w_cap),
        .i_wr_data (data_in),
        .i_rd_en   (out_ready),
        .o_rd_data (out_data),
        .o_level   (level),
        .o_full    (w_full),
        .o_empty   (w_empty)
    );

endmodule

// File: tb/tb_pipe_result_collector.sv
// tb/tb_pipe_result_collector.sv - self-checking bench for pipe_result_collector
module tb_pipe_result_collector;
    import pipe_result_collector_pkg::*;

    localparam int LAT   = PRC_LAT;
    localparam int DEPTH = 4;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       clear;
    logic       issue_valid;
    result_t    data_in;
    logic       out_valid;
    result_t    out_data;
    logic       out_ready;
    logic [2:0] level;
    logic       overflow;
    logic [7:0] drop_count;

    int total = 0;
    int bad   = 0;

    // Reference model: queued results, edge numbers at which issued results are due
    result_t mq[$];
    int      due[$];
    int      edge_n = 0;
    logic    m_ov   = 1'b0;
    int      m_dc   = 0;

    typedef struct {
        logic       iv;
        result_t    din;
        logic       rdy;
        logic       clr;
        logic       ev;
        result_t    ed;
        logic [2:0] el;
    } vec_t;

    vec_t tbl[14];
    int   sv[$];

    pipe_result_collector dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .clear       (clear),
        .issue_valid (issue_valid),
        .data_in     (data_in),
        .out_valid   (out_valid),
        .out_data    (out_data),
        .out_ready   (out_ready),
        .level       (level),
        .overflow    (overflow),
        .drop_count  (drop_count)
    );

    always #5 clk = ~clk;

    function automatic vec_t mk(input logic iv, input int din, input logic rdy, input logic clr,
                                input logic ev, input int ed, input int el);
        vec_t v;
        v.iv = iv; v.din = result_t'(din); v.rdy = rdy; v.clr = clr;
        v.ev = ev; v.ed = result_t'(ed); v.el = 3'(el);
        return v;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%0d required=%0d (edge %0d)", nm, act, exp, edge_n);
        end
    endtask

    task automatic model_reset();
        mq.delete();
        due.delete();
        m_ov = 1'b0;
        m_dc = 0;
    endtask

    task automatic model_edge();
        logic cap;
        logic rd;
        if (clear) begin
            model_reset();
        end else begin
            cap = 1'b0;
            if (due.size() != 0 && due[0] == edge_n) begin
                cap = 1'b1;
                void'(due.pop_front());
            end
            rd = (mq.size() != 0) && out_ready;
            if (rd) void'(mq.pop_front());
            if (cap) begin
                if (mq.size() < DEPTH) begin
                    mq.push_back(data_in);
                end else begin
                    m_ov = 1'b1;
                    if (m_dc < 255) m_dc++;
                end
            end
            if (issue_valid) due.push_back(edge_n + LAT);
        end
        edge_n++;
    endtask

    task automatic check_model();
        chk("m_valid", 32'(out_valid), 32'(mq.size() != 0));
        chk("m_level", 32'(level), 32'(mq.size()));
        chk("m_data", 32'(out_data), (mq.size() != 0) ? 32'(mq[0]) : 32'd0);
        chk("m_overflow", 32'(overflow), 32'(m_ov));
        chk("m_drop_count", 32'(drop_count), 32'(m_dc));
    endtask

    task automatic step();
        @(posedge clk);
        model_edge();
        #1;
        check_model();
    endtask

    task automatic idle();
        issue_valid = 1'b0;
        out_ready   = 1'b0;
        clear       = 1'b0;
        data_in     = 10'd999;
    endtask

    // Issues sv back-to-back and drives each result exactly LAT edges after its issue edge
    task automatic stream(input int rdy_at, input int clr_at);
        int n;
        n = sv.size();
        for (int c = 0; c < n + LAT; c++) begin
            issue_valid = (c < n);
            data_in     = (c >= LAT) ? result_t'(sv[c-LAT]) : 10'd999;
            out_ready   = (c == rdy_at);
            clear       = (c == clr_at);
            step();
        end
        idle();
    endtask

    task automatic pop_expect(input string nm, input int exp);
        chk(nm, 32'(out_data), 32'(exp));
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
    endtask

    initial begin
        // Latency alignment then back-to-back stream with out_ready high
        tbl[0]  = mk(1, 999, 0, 0, 0, 0, 0);
        tbl[1]  = mk(0, 999, 0, 0, 0, 0, 0);
        tbl[2]  = mk(0, 999, 0, 0, 0, 0, 0);
        tbl[3]  = mk(0, 32,  0, 0, 1, 32, 1);
        tbl[4]  = mk(0, 999, 0, 0, 1, 32, 1);
        tbl[5]  = mk(0, 999, 1, 0, 0, 0, 0);
        tbl[6]  = mk(1, 0,   1, 0, 0, 0, 0);
        tbl[7]  = mk(1, 0,   1, 0, 0, 0, 0);
        tbl[8]  = mk(1, 0,   1, 0, 0, 0, 0);
        tbl[9]  = mk(1, 10,  1, 0, 1, 10, 1);
        tbl[10] = mk(0, 20,  1, 0, 1, 20, 1);
        tbl[11] = mk(0, 30,  1, 0, 1, 30, 1);
        tbl[12] = mk(0, 40,  1, 0, 1, 40, 1);
        tbl[13] = mk(0, 999, 1, 0, 0, 0, 0);

        rst_n = 1'b0;
        idle();
        repeat (2) @(posedge clk);
        #1;
        chk("rst_valid", 32'(out_valid), 0);
        chk("rst_level", 32'(level), 0);
        chk("rst_data", 32'(out_data), 0);
        chk("rst_overflow", 32'(overflow), 0);
        chk("rst_drop", 32'(drop_count), 0);
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < 14; i++) begin
            issue_valid = tbl[i].iv;
            data_in     = tbl[i].din;
            out_ready   = tbl[i].rdy;
            clear       = tbl[i].clr;
            step();
            chk($sformatf("tbl%0d_valid", i), 32'(out_valid), 32'(tbl[i].ev));
            chk($sformatf("tbl%0d_data", i), 32'(out_data), 32'(tbl[i].ed));
            chk($sformatf("tbl%0d_level", i), 32'(level), 32'(tbl[i].el));
            chk($sformatf("tbl%0d_overflow", i), 32'(overflow), 0);
        end
        idle();

        // Full FIFO with a simultaneous read on the capture of 9
        sv = {5, 6, 7, 8, 9};
        stream(4 + LAT, -1);
        chk("fr_level", 32'(level), 4);
        chk("fr_head", 32'(out_data), 6);
        chk("fr_overflow", 32'(overflow), 0);
        pop_expect("fr_pop0", 6);
        pop_expect("fr_pop1", 7);
        pop_expect("fr_pop2", 8);
        pop_expect("fr_pop3", 9);
        chk("fr_empty", 32'(out_valid), 0);

        // Fill, then 300 further results with no room: counter saturates
        sv.delete();
        for (int i = 0; i < 304; i++) sv.push_back(100 + i);
        stream(-1, -1);
        chk("ov_flag", 32'(overflow), 1);
        chk("ov_count", 32'(drop_count), 255);
        chk("ov_level", 32'(level), 4);
        pop_expect("ov_pop0", 100);
        pop_expect("ov_pop1", 101);
        pop_expect("ov_pop2", 102);
        pop_expect("ov_pop3", 103);
        chk("ov_sticky", 32'(overflow), 1);

        // Clear on the same edge as a capture and a read with level 3
        sv = {50, 51, 52, 53};
        stream(3 + LAT, 3 + LAT);
        chk("clr_level", 32'(level), 0);
        chk("clr_valid", 32'(out_valid), 0);
        chk("clr_overflow", 32'(overflow), 0);
        chk("clr_drop", 32'(drop_count), 0);
        repeat (LAT + 2) step();
        chk("clr_no_late_write", 32'(level), 0);

        // Asynchronous reset between edges with level 2 and a prior overflow
        sv = {70, 71, 72, 73, 74, 75};
        stream(-1, -1);
        pop_expect("rs_pop0", 70);
        pop_expect("rs_pop1", 71);
        chk("rs_pre_level", 32'(level), 2);
        #2;
        rst_n = 1'b0;
        #1;
        chk("rs_valid", 32'(out_valid), 0);
        chk("rs_level", 32'(level), 0);
        chk("rs_overflow", 32'(overflow), 0);
        chk("rs_drop", 32'(drop_count), 0);
        chk("rs_data", 32'(out_data), 0);
        model_reset();
        @(posedge clk);
        edge_n++;
        @(negedge clk);
        rst_n = 1'b1;

        // Randomised traffic against the reference model
        for (int i = 0; i < 1500; i++) begin
            issue_valid = ($urandom_range(0, 3) != 0);
            data_in     = result_t'($urandom_range(0, 1023));
            out_ready   = (i < 750) ? ($urandom_range(0, 3) != 0) : ($urandom_range(0, 4) == 0);
            clear       = ($urandom_range(0, 199) == 0);
            step();
        end
        idle();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/pipe_result_collector.md
Name: pipe_result_collector

Overview:
- Downstream consumer of the 10-bit arithmetic pipeline (operands A/B/C/D in, result F out, fixed latency, no stall).
- Re-associates each issued operand set with its result by carrying an issue-valid bit through a delay line matched to the pipeline latency.
- Captures valid results into a small FIFO and presents them on a valid/ready interface.
- Flags, and does not silently lose, results arriving when the FIFO cannot accept them.

Parameters:
- N, 10, result data width; matches the pipeline width parameter.
- LAT, 3, pipeline latency in clock cycles from operand sampling to F valid; legal range 1..8.
- DEPTH, 4, FIFO entries; power of two, minimum 2.
- DROP_W, 8, width of the saturating dropped-result counter.

Ports:
- clk, input, 1, system clock; all state updates on the rising edge.
- rst_n, input, 1, asynchronous active-low reset.
- clear, input, 1, synchronous flush of delay line, FIFO, overflow flag and drop counter.
- issue_valid, input, 1, high in the cycle a real operand set is sampled by the pipeline.
- data_in, input, N, pipeline result F.
- out_valid, output, 1, FIFO non-empty.
- out_data, output, N, FIFO head entry; first-word fall-through.
- out_ready, input, 1, consumer accepts the head when out_valid is also high.
- level, output, $clog2(DEPTH+1), current FIFO occupancy.
- overflow, output, 1, sticky; set when a valid result is dropped.
- drop_count, output, DROP_W, number of dropped results; saturates at all-ones.

Behaviour:
- Reset: rst_n low asynchronously zeroes the delay line, FIFO pointers, level, overflow and drop_count.
  - out_valid is 0 and out_data reads 0 during and after reset.
  - Storage contents need not be reset.
  - Deassertion is synchronous to clk; it is synchronised outside this block.
- Delay line: LAT-bit shift register; stage 0 loads issue_valid each edge.
  - cap = last stage.
  - A result on data_in is valid at the edge exactly LAT edges after the edge that sampled issue_valid=1.
- Read: rd = out_valid & out_ready. The head advances at the edge; out_data shows the next entry in the following cycle.
- Write, when cap=1:
  - Not full: write data_in at the tail.
  - Full and rd=1: write is accepted; level unchanged.
  - Full and rd=0: result is dropped; overflow <= 1; drop_count increments unless saturated.
- Simultaneous read and write when not empty and not full: level unchanged, FIFO order preserved.
- Empty with cap=1: the entry appears on out_data with out_valid=1 in the cycle after the capture edge. Latency from data_in to out_data is 1 cycle.
- Pointers: log2(DEPTH) bits, wrap naturally. Full/empty are derived from level, not pointer compare.
- clear=1 at an edge:
  - Zeroes the delay line, pointers, level, overflow and drop_count.
  - Takes priority over any cap and rd in that cycle; that capture is discarded and not counted as a drop.
  - Operands issued in the LAT cycles before clear are lost by design.
- issue_valid=0 cycles produce no writes regardless of data_in (pipeline bubbles ignored).
- level is never greater than DEPTH. out_valid == (level != 0) at all times.

Decomposition:
- Shared package: N default, LAT default, and the result data typedef, shared with the pipeline and its bench so the widths/latency cannot drift.
- One sub-module, sync_fifo_fwft: DEPTH/N parameters, wr/rd/clear, level, full/empty.
- The delay line and overflow/drop logic stay in pipe_result_collector.

Test Plan:
- Reset mid-stream: rst_n pulsed low between edges while level=2 -> out_valid, level, overflow and drop_count are 0 immediately, without waiting for clk.
- Latency alignment: issue_valid=1 for one cycle at edge k; data_in driven to 32 exactly at edge k+3, with garbage 999 at k+2 and k+4 -> out_valid rises after k+3 with out_data=32, level=1.
- Back-to-back stream: issue_valid held high for 4 cycles with results 10, 20, 30, 40 and out_ready=1 -> outputs 10, 20, 30, 40 in order, one per cycle; level never exceeds 1; overflow stays 0.
- Full plus simultaneous read: out_ready=0, fill with 5, 6, 7, 8 (level=4); next result 9 arrives with out_ready=1 -> 5 popped, 9 written, level stays 4, overflow=0; then pops yield 6, 7, 8, 9.
- Overflow/saturation: FIFO full with out_ready=0, then 300 further valid results with DROP_W=8 -> overflow=1, drop_count=255, FIFO contents unchanged.
- Clear priority: clear=1 on the same edge as cap=1 and rd=1 with level=3 -> level=0, out_valid=0, overflow=0, drop_count=0, and no later write from that capture.
